dout_pwm_array: RTL and testbench

DOUT_PWM_ARRAY -- requirements
Module: dout_pwm_array

---
 rtl/dout_pwm_array.sv | 139 +++++++++++++
 tb/tb_dout_pwm_array.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dout_pwm_array.sv
// dout_pwm_array: per-channel PWM timers with shadowed {high,low} times and direct output writes.
// Optional pulse-count limit enabled by defining DOUT_PULSE_CNT_EN.
module dout_pwm_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               ctrl_wen,
    input  logic [CH_W-1:0]    ctrl_ch,
    input  logic [2*CNT_W-1:0] ctrl_wdata,
    input  logic [CH_W-1:0]    rd_ch,
    output logic [2*CNT_W-1:0] rd_data,
    input  logic               dout_wen,
    input  logic [NUM_CH-1:0]  dout_mask,
    input  logic [NUM_CH-1:0]  dout_val,
`ifdef DOUT_PULSE_CNT_EN
    input  logic               cnt_wen,
    input  logic [15:0]        cnt_wdata,
    output logic [NUM_CH-1:0]  done,
`endif
    output logic [NUM_CH-1:0]  dout,
    output logic [NUM_CH-1:0]  pending
);

    logic [NUM_CH-1:0][2*CNT_W-1:0] act_q, act_d, sh_q, sh_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              dout_q, dout_d, pend_q, pend_d;
`ifdef DOUT_PULSE_CNT_EN
    logic [NUM_CH-1:0][15:0]        lim_q, lim_d, pc_q, pc_d;
    logic [NUM_CH-1:0]              done_q, done_d;
    logic                           cw;
`endif
    logic [CNT_W-1:0]               t;
    logic                           frz, idle, tick, bnd, wr, dw;

    always_comb begin
        act_d  = act_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        pend_d = pend_q;
`ifdef DOUT_PULSE_CNT_EN
        lim_d  = lim_q;
        pc_d   = pc_q;
        done_d = done_q;
        cw     = 1'b0;
`endif
        t    = '0;
        frz  = 1'b0;
        idle = 1'b0;
        tick = 1'b0;
        bnd  = 1'b0;
        wr   = 1'b0;
        dw   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            t = dout_q[i] ? act_q[i][2*CNT_W-1:CNT_W] : act_q[i][CNT_W-1:0];
`ifdef DOUT_PULSE_CNT_EN
            frz = done_q[i];
            cw  = cnt_wen && ctrl_ch == CH_W'(i);
`endif
            idle = t == '0 || frz;
            tick = !idle && cnt_q[i] == t - CNT_W'(1);
            bnd  = idle || (tick && !dout_q[i]);
            wr   = ctrl_wen && ctrl_ch == CH_W'(i);
            dw   = dout_wen && dout_mask[i];
            cnt_d[i]  = (idle || tick) ? '0 : cnt_q[i] + CNT_W'(1);
            dout_d[i] = dout_q[i] ^ tick;
            if (dw) begin
                dout_d[i] = dout_val[i];
                cnt_d[i]  = '0;
            end
            if ((dw || bnd) && pend_q[i]) begin
                act_d[i]  = sh_q[i];
                pend_d[i] = 1'b0;
            end
            // a write alongside a direct output write bypasses the shadow
            if (wr) begin
                sh_d[i]   = ctrl_wdata;
                pend_d[i] = !dw;
                if (dw)
                    act_d[i] = ctrl_wdata;
            end
`ifdef DOUT_PULSE_CNT_EN
            if (tick && dout_q[i] && lim_q[i] != '0) begin
                pc_d[i]   = pc_q[i] + 16'd1;
                done_d[i] = pc_d[i] == lim_q[i];
            end
            if (dw || cw) begin
                pc_d[i]   = '0;
                done_d[i] = 1'b0;
            end
            if (cw)
                lim_d[i] = cnt_wdata;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rd_ch == CH_W'(i))
                rd_data = act_q[i];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            act_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            pend_q <= '0;
`ifdef DOUT_PULSE_CNT_EN
            lim_q  <= '0;
            pc_q   <= '0;
            done_q <= '0;
`endif
        end else begin
            act_q  <= act_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            pend_q <= pend_d;
`ifdef DOUT_PULSE_CNT_EN
            lim_q  <= lim_d;
            pc_q   <= pc_d;
            done_q <= done_d;
`endif
        end
    end

    assign dout    = dout_q;
    assign pending = pend_q;
`ifdef DOUT_PULSE_CNT_EN
    assign done    = done_q;
`endif

endmodule

// File: tb/tb_dout_pwm_array.sv
// tb_dout_pwm_array: directed checks of PWM timing, shadow updates, direct writes and reset.
module tb_dout_pwm_array;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic               sysclk = 1'b0;
    logic               reset;
    logic               ctrl_wen;
    logic [CH_W-1:0]    ctrl_ch;
    logic [2*CNT_W-1:0] ctrl_wdata;
    logic [CH_W-1:0]    rd_ch;
    logic [2*CNT_W-1:0] rd_data;
    logic               dout_wen;
    logic [NUM_CH-1:0]  dout_mask, dout_val, dout, pending;
`ifdef DOUT_PULSE_CNT_EN
    logic               cnt_wen;
    logic [15:0]        cnt_wdata;
    logic [NUM_CH-1:0]  done;
`endif

    int checks = 0;
    int errors = 0;

    dout_pwm_array #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .sysclk(sysclk), .reset(reset),
        .ctrl_wen(ctrl_wen), .ctrl_ch(ctrl_ch), .ctrl_wdata(ctrl_wdata),
        .rd_ch(rd_ch), .rd_data(rd_data),
        .dout_wen(dout_wen), .dout_mask(dout_mask), .dout_val(dout_val),
`ifdef DOUT_PULSE_CNT_EN
        .cnt_wen(cnt_wen), .cnt_wdata(cnt_wdata), .done(done),
`endif
        .dout(dout), .pending(pending)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic ctrl(input int ch, input int hi, input int lo);
        ctrl_wen   = 1'b1;
        ctrl_ch    = CH_W'(ch);
        ctrl_wdata = {CNT_W'(hi), CNT_W'(lo)};
        step();
        ctrl_wen   = 1'b0;
    endtask

    task automatic dwr(input logic [NUM_CH-1:0] m, input logic [NUM_CH-1:0] v);
        dout_wen  = 1'b1;
        dout_mask = m;
        dout_val  = v;
        step();
        dout_wen  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; ctrl_wen = 1'b0; ctrl_ch = '0; ctrl_wdata = '0; rd_ch = '0;
        dout_wen = 1'b0; dout_mask = '0; dout_val = '0;
`ifdef DOUT_PULSE_CNT_EN
        cnt_wen = 1'b0; cnt_wdata = '0;
`endif
        step(2);
        check("rst_dout", dout, 0);
        check("rst_pend", pending, 0);
        check("rst_rd", rd_data, 0);
        reset = 1'b0;

        ctrl(0, 3, 5);
        check("ctl_pend", pending, 3'b001);
        check("ctl_rd_old", rd_data, 0);
        step();
        check("idle_apply_pend", pending, 0);
        check("idle_apply_rd", rd_data, {16'd3, 16'd5});

        ctrl(3, 9, 9);
        check("inv_pend", pending, 0);
        rd_ch = 2'd3; #1;
        check("inv_rd", rd_data, 0);
        rd_ch = 2'd0; #1;

        dwr(3'b001, 3'b001);
        for (int k = 0; k < 24; k++) begin
            check($sformatf("pwm35[%0d]", k), dout[0], (k % 8) < 3);
            step();
        end

        step();
        ctrl(0, 6, 2);
        check("recfg_pend", pending[0], 1);
        check("recfg_rd_old", rd_data, {16'd3, 16'd5});
        for (int j = 0; j < 22; j++) begin
            check($sformatf("recfg_dout[%0d]", j), dout[0], j < 1 ? 1'b1 : j < 6 ? 1'b0 : ((j - 6) % 8) < 6);
            check($sformatf("recfg_pend[%0d]", j), pending[0], j < 6);
            if (j == 6) check("recfg_rd_new", rd_data, {16'd6, 16'd2});
            step();
        end

        ctrl(1, 10, 0);
        step();
        dwr(3'b010, 3'b010);
        for (int j = 0; j < 15; j++) begin
            check($sformatf("oneshot[%0d]", j), dout[1], j < 10);
            step();
        end

        rd_ch = 2'd1;
        ctrl(1, 5, 0);
        ctrl(1, 7, 0);
        check("bnd_wr_pend", pending[1], 1);
        check("bnd_wr_rd", rd_data, {16'd5, 16'd0});
        step();
        check("bnd_wr_pend2", pending[1], 0);
        check("bnd_wr_rd2", rd_data, {16'd7, 16'd0});

        rd_ch = 2'd2;
        dout_wen = 1'b1; dout_mask = 3'b101; dout_val = 3'b001;
        ctrl(2, 4, 4);
        dout_wen = 1'b0;
        check("sim_dout0", dout[0], 1);
        check("sim_dout2", dout[2], 0);
        check("sim_pend2", pending[2], 0);
        check("sim_rd2", rd_data, {16'd4, 16'd4});
        for (int j = 0; j < 8; j++) begin
            check($sformatf("pwm44[%0d]", j), dout[2], j >= 4);
            step();
        end

        rd_ch = 2'd0;
        n = 0;
        while (dout[0] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("wait_high", dout[0], 1);
        step();
        reset = 1'b1;
        ctrl(0, 1, 1);
        reset = 1'b0;
        check("midrst_dout", dout, 0);
        check("midrst_pend", pending, 0);
        check("midrst_rd", rd_data, 0);

`ifdef DOUT_PULSE_CNT_EN
        ctrl(0, 2, 2);
        step();
        cnt_wen = 1'b1; ctrl_ch = 2'd0; cnt_wdata = 16'd3;
        step();
        cnt_wen = 1'b0;
        check("lim_done0", done, 0);
        dwr(3'b001, 3'b001);
        for (int j = 0; j < 20; j++) begin
            check($sformatf("lim_dout[%0d]", j), dout[0], j < 10 && (j % 4) < 2);
            check($sformatf("lim_done[%0d]", j), done[0], j >= 10);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
